// File: rtl/blinky_led_ctrl_if.sv
// Avalon-MM slave bus bundle for the LED port controller.
// The master drives address/strobes/data; the slave returns combinational readdata.
interface blinky_led_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/blinky_led_ctrl.sv
// LED output port: data register with atomic set/clear, plus a blink engine
// that gates masked bits with a programmable half-period square wave.
module blinky_led_ctrl #(
    parameter int unsigned WIDTH        = 8,
    parameter logic [31:0] RESET_VALUE  = 32'd0,
    parameter int unsigned PERIOD_WIDTH = 24,
    parameter logic [31:0] PERIOD_RESET = 32'd12499999
) (
    input  logic               clk,
    input  logic               reset_n,
    blinky_led_ctrl_if.slave   bus,
    output logic [WIDTH-1:0]   out_port
);

    logic [WIDTH-1:0]        data_q,   data_d;
    logic [WIDTH-1:0]        mask_q,   mask_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic                    run_q,    run_d;
    logic [PERIOD_WIDTH-1:0] cnt_q,    cnt_d;
    logic                    phase_q,  phase_d;

    logic                    wr_s;
    logic [WIDTH-1:0]        wd_s;
    logic [PERIOD_WIDTH-1:0] wd_period_s;

    assign wr_s        = bus.chipselect & ~bus.write_n;
    assign wd_s        = bus.writedata[WIDTH-1:0];
    assign wd_period_s = bus.writedata[PERIOD_WIDTH-1:0];

    // Register file next-state from bus writes
    always_comb begin
        data_d   = data_q;
        mask_d   = mask_q;
        period_d = period_q;
        run_d    = run_q;
        if (wr_s) begin
            case (bus.address)
                3'd0:    data_d   = wd_s;
                3'd1:    mask_d   = wd_s;
                3'd2:    period_d = wd_period_s;
                3'd3:    run_d    = bus.writedata[0];
                3'd4:    data_d   = data_q | wd_s;
                3'd5:    data_d   = data_q & ~wd_s;
                default: data_d   = data_q;
            endcase
        end else begin
            data_d = data_q;
        end
    end

    // Blink engine next-state; engine-register writes override a coincident expiry
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (wr_s && bus.address == 3'd2) begin
            cnt_d   = wd_period_s;
            phase_d = 1'b1;
        end else if (wr_s && bus.address == 3'd3 && !(run_q && bus.writedata[0])) begin
            // Stopping or starting both restart the wave from a lit phase
            cnt_d   = period_q;
            phase_d = 1'b1;
        end else if (wr_s && bus.address == 3'd3) begin
            cnt_d   = (cnt_q == '0) ? period_q : cnt_q - PERIOD_WIDTH'(1);
            phase_d = phase_q;
        end else if (!run_q) begin
            cnt_d   = period_q;
            phase_d = 1'b1;
        end else if (cnt_q == '0) begin
            cnt_d   = period_q;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q - PERIOD_WIDTH'(1);
            phase_d = phase_q;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= RESET_VALUE[WIDTH-1:0];
            mask_q   <= '0;
            period_q <= PERIOD_RESET[PERIOD_WIDTH-1:0];
            run_q    <= 1'b0;
            cnt_q    <= PERIOD_RESET[PERIOD_WIDTH-1:0];
            phase_q  <= 1'b1;
        end else begin
            data_q   <= data_d;
            mask_q   <= mask_d;
            period_q <= period_d;
            run_q    <= run_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
        end
    end

    // Zero-latency read mux
    always_comb begin
        case (bus.address)
            3'd0:    bus.readdata = 32'(data_q);
            3'd1:    bus.readdata = 32'(mask_q);
            3'd2:    bus.readdata = 32'(period_q);
            3'd3:    bus.readdata = {30'd0, phase_q, run_q};
            default: bus.readdata = 32'd0;
        endcase
    end

    assign out_port = data_q & (~mask_q | {WIDTH{phase_q}});

endmodule

// File: tb/tb_blinky_led_ctrl.sv
// Self-checking bench: directed register/blink scenarios plus randomized bus
// traffic compared against a time-based reference model of the blink wave.
module tb_blinky_led_ctrl;

    localparam int unsigned PR = 12499999;

    logic       clk;
    logic       reset_n;
    logic [7:0] out_port;

    blinky_led_ctrl_if bus ();

    blinky_led_ctrl #(
        .WIDTH        (8),
        .RESET_VALUE  (32'h000000A5),
        .PERIOD_WIDTH (24),
        .PERIOD_RESET (32'd12499999)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .out_port (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: phase derived from elapsed edges since the wave was (re)started
    int          cyc;
    int          m_load;
    bit          m_run;
    int unsigned m_per;
    logic [7:0]  m_data;
    logic [7:0]  m_mask;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_phase();
        if (!m_run) return 1'b1;
        return 1'b1 ^ (((cyc - m_load) / (m_per + 1)) % 2 == 1);
    endfunction

    function automatic logic [7:0] m_out();
        return m_data & (~m_mask | {8{m_phase()}});
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return {24'd0, m_data};
            3'd1:    return {24'd0, m_mask};
            3'd2:    return m_per;
            3'd3:    return {30'd0, m_phase(), m_run};
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        cyc = 0; m_load = 0; m_run = 1'b0; m_per = PR;
        m_data = 8'hA5; m_mask = 8'h00;
    endtask

    task automatic m_write(input logic [2:0] a, input logic [31:0] d);
        case (a)
            3'd0: m_data = d[7:0];
            3'd1: m_mask = d[7:0];
            3'd2: begin m_per = d[23:0]; m_load = cyc; end
            3'd3: begin
                if (d[0] && !m_run) m_load = cyc;
                m_run = d[0];
            end
            3'd4: m_data = m_data | d[7:0];
            3'd5: m_data = m_data & ~d[7:0];
            default: m_data = m_data;
        endcase
    endtask

    // One clock edge with whatever is on the bus; model follows at the same edge
    task automatic tick();
        @(posedge clk);
        cyc++;
        if (bus.chipselect && !bus.write_n) m_write(bus.address, bus.writedata);
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        tick();
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic read_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
        #1;
        check_val(tag, bus.readdata, exp);
        bus.chipselect = 1'b0;
    endtask

    initial begin
        bus.address = 3'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'd0;
        reset_n = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        m_reset();

        // Reset state
        #1;
        check_val("rst_out", {24'd0, out_port}, 32'h000000A5);
        read_check("rst_data", 3'd0, 32'h000000A5);
        read_check("rst_period", 3'd2, PR);
        read_check("rst_ctrl", 3'd3, 32'h00000002);

        // Data, set, clear and unmapped reads
        bus_write(3'd0, 32'hFFFFFF3C);
        read_check("data_wr", 3'd0, 32'h0000003C);
        bus_write(3'd4, 32'hFFFFFF01);
        read_check("outset", 3'd0, 32'h0000003D);
        bus_write(3'd5, 32'h0000000C);
        read_check("outclr", 3'd0, 32'h00000031);
        #1 check_val("outclr_port", {24'd0, out_port}, 32'h00000031);
        for (int a = 4; a < 8; a++) read_check($sformatf("rd_zero%0d", a), 3'(a), 32'd0);

        // Blink with PERIOD=3: 4 cycles per phase
        bus_write(3'd0, 32'h000000FF);
        bus_write(3'd1, 32'h0000000F);
        bus_write(3'd2, 32'h00000003);
        bus_write(3'd3, 32'h00000001);
        for (int i = 0; i < 16; i++) begin
            #1;
            check_val("blink3_out", {24'd0, out_port}, ((i / 4) % 2 == 1) ? 32'hF0 : 32'hFF);
            read_check("blink3_phase", 3'd3, ((i / 4) % 2 == 1) ? 32'h1 : 32'h3);
            tick();
        end

        // PERIOD=0 toggles every cycle; clearing RUN restores steady DATA
        bus_write(3'd2, 32'h00000000);
        for (int i = 0; i < 6; i++) begin
            #1 check_val("p0_out", {24'd0, out_port}, (i % 2 == 1) ? 32'hF0 : 32'hFF);
            check_val("p0_model", {24'd0, out_port}, {24'd0, m_out()});
            tick();
        end
        bus_write(3'd3, 32'h00000000);
        #1 check_val("run_off", {24'd0, out_port}, 32'hFF);
        repeat (5) begin
            tick();
            #1 check_val("run_off_hold", {24'd0, out_port}, 32'hFF);
        end

        // PERIOD write landing on the expiry edge suppresses the toggle
        bus_write(3'd2, 32'h00000003);
        bus_write(3'd3, 32'h00000001);
        repeat (3) tick();
        bus_write(3'd2, 32'h00000009);
        read_check("coinc_phase", 3'd3, 32'h3);
        for (int i = 1; i <= 10; i++) begin
            tick();
            #1 check_val("coinc_out", {24'd0, out_port}, (i == 10) ? 32'hF0 : 32'hFF);
        end

        // Randomized traffic against the model (CONTROL writes always flip RUN)
        for (int it = 0; it < 400; it++) begin
            int unsigned op;
            logic [31:0] d;
            logic [2:0]  ra;
            op = $urandom_range(0, 9);
            d  = $urandom;
            case (op)
                5: bus_write(3'($urandom_range(0, 1)), d);
                6: bus_write(3'd2, 32'($urandom_range(0, 5)) | (d & 32'hFF000000));
                7: bus_write(3'd3, (d & 32'hFFFFFFFE) | {31'd0, ~m_run});
                8: bus_write(3'($urandom_range(6, 7)), d);
                9: bus_write(3'($urandom_range(4, 5)), d);
                default: tick();
            endcase
            #1 check_val("rand_out", {24'd0, out_port}, {24'd0, m_out()});
            ra = 3'($urandom_range(0, 7));
            read_check($sformatf("rand_rd%0d", ra), ra, m_read(ra));
        end

        // Asynchronous reset between edges while blinking
        bus_write(3'd0, 32'h000000FF);
        bus_write(3'd1, 32'h000000FF);
        bus_write(3'd2, 32'h00000001);
        bus_write(3'd3, 32'h00000001);
        repeat (2) tick();
        #2 reset_n = 1'b0;
        #1 check_val("arst_out", {24'd0, out_port}, 32'h000000A5);
        bus.address = 3'd3; bus.chipselect = 1'b1; bus.write_n = 1'b1;
        #1 check_val("arst_ctrl", bus.readdata, 32'h00000002);
        bus.chipselect = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        m_reset();
        read_check("arst_period", 3'd2, PR);
        bus_write(3'd1, 32'h000000FF);
        bus_write(3'd2, 32'h00000001);
        bus_write(3'd3, 32'h00000001);
        for (int i = 0; i < 6; i++) begin
            #1 check_val("post_rst_out", {24'd0, out_port}, ((i / 2) % 2 == 1) ? 32'h00 : 32'hA5);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/blinky_led_ctrl.md
# blinky_led_ctrl

Parametrised Avalon-MM output-port controller for board LEDs: a WIDTH-bit software-written data register, atomic per-bit set and clear registers, and a hardware blink engine that gates selected bits with a programmable-period square wave. It is the drop-in successor to the 2-bit LED PIO on the Nios II system bus. Software can blink LEDs without CPU polling.

## Interface
- WIDTH, 8, output-port width, 1..32
- RESET_VALUE, 0, DATA register reset value (WIDTH bits)
- PERIOD_WIDTH, 24, width of PERIOD register and half-period counter, 1..32
- PERIOD_RESET, 12499999, PERIOD reset value; gives 250 ms half-period at 50 MHz

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  word address of register
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe, qualified by chipselect
- writedata  in  32  write data
- readdata  out  32  read data, zero-extended, combinational from address
- out_port  out  WIDTH  LED drive

Reset and clock: reset reset_n, asynchronous, active-low; clock clk.

## Operation
Register map (write = chipselect & ~write_n):
- 0 DATA, rw, WIDTH bits: write loads writedata[WIDTH-1:0].
- 1 BLINK_MASK, rw, WIDTH bits: a 1 in a bit position makes that bit blink.
- 2 PERIOD, rw, PERIOD_WIDTH bits: half-period minus 1, in clk cycles.
- 3 CONTROL: bit0 RUN is rw. bit1 PHASE is read-only. Other bits read 0.
- 4 OUTSET, write-only: DATA <= DATA | writedata[WIDTH-1:0]. Reads return 0.
- 5 OUTCLR, write-only: DATA <= DATA & ~writedata[WIDTH-1:0]. Reads return 0.
- 6, 7: reserved. Writes are ignored and reads return 0.

Blink engine:
- Registers: down-counter cnt[PERIOD_WIDTH-1:0] and phase bit.
- RUN=1: when cnt==0, cnt <= PERIOD and phase <= ~phase. Otherwise cnt <= cnt-1.
- Each phase therefore lasts PERIOD+1 cycles. PERIOD=0 toggles phase every cycle.
- RUN=0: cnt <= PERIOD and phase <= 1, so blinking bits show steady DATA.
- Write to PERIOD: cnt <= writedata[PERIOD_WIDTH-1:0] and phase <= 1.
- Write to CONTROL with RUN 0->1: cnt <= PERIOD and phase <= 1.
- A register write and a counter expiry in the same cycle: the write wins, and the expiry is discarded.

Output: out_port[i] = DATA[i] & (~BLINK_MASK[i] | phase). The output is combinational from the registers and has no extra flop.

Reset values:
- DATA = RESET_VALUE, BLINK_MASK = 0, PERIOD = PERIOD_RESET.
- RUN = 0, cnt = PERIOD_RESET, phase = 1.
- Therefore out_port = RESET_VALUE.

Width rules:
- Write bits above WIDTH or PERIOD_WIDTH are ignored.
- readdata upper bits are 0.

## Timing
- Read latency 0: readdata is valid in the same cycle address is presented. There is no waitrequest.
- Writes take effect at the rising clk edge where chipselect & ~write_n. The new out_port is visible in the following cycle.
- Phase toggles exactly PERIOD+1 cycles after the edge that loaded cnt, then every PERIOD+1 cycles after that.
- Reset assertion mid-blink clears all state immediately (asynchronous). The first toggle after release and RUN=1 is at PERIOD+1 cycles.
- PERIOD reads back the written value immediately. The change to cnt is not visible on the bus.

## Test plan
- Reset with RESET_VALUE=8'hA5: out_port=8'hA5, read addr0=32'h000000A5, addr2=PERIOD_RESET, addr3=32'h2.
- Write DATA=32'hFFFFFF3C with WIDTH=8: readback 32'h0000003C. Then OUTSET 8'h01 -> 8'h3D. Then OUTCLR 8'h0C -> 8'h31. Reads of addr 4, 5, 6, 7 return 0.
- DATA=8'hFF, MASK=8'h0F, PERIOD=3, RUN=1: out_port alternates 8'hFF and 8'hF0 every 4 cycles. CONTROL.PHASE tracks this.
- PERIOD=0, RUN=1: phase toggles every cycle. Clearing RUN forces out_port=DATA on the next cycle.
- Write PERIOD=9 in the same cycle cnt reaches 0: no toggle occurs, phase=1, and the next toggle is 10 cycles later.
- Assert reset_n low for 1 cycle mid-blink (asynchronous, between edges): out_port returns to RESET_VALUE immediately and RUN reads 0.
